// File: rtl/cpld_link_pkg.sv
// Shared constants, state encoding and arbitration helper for the CPLD serial link.
package cpld_link_pkg;

    localparam int FRAME_BITS = 16;
    localparam int RX_BITS    = 13;
    localparam int SW_LSB     = 0;
    localparam int NAV_LSB    = 8;
    localparam int NAV_W      = 5;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } link_state_t;

    // Round-robin pick: ptr==0 favours requester 0 when both ask.
    function automatic logic [1:0] arb_pick(input logic [1:0] req, input logic ptr);
        if (req[0] && (!req[1] || !ptr)) return 2'b01;
        if (req[1]) return 2'b10;
        return 2'b00;
    endfunction

endpackage

// File: rtl/cpld_nav_debounce.sv
// Per-lane frame-count debouncer for the nav switches; pulses an event on a settled 0->1.
module cpld_nav_debounce
    import cpld_link_pkg::*;
#(
    parameter int DEB_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [NAV_W-1:0] raw,
    output logic [NAV_W-1:0] level,
    output logic [NAV_W-1:0] nav_event
);

    generate
        for (genvar gi = 0; gi < NAV_W; gi++) begin : g_lane
            logic [3:0] cnt;
            logic       lvl;
            logic       evt;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt <= '0;
                    lvl <= 1'b0;
                    evt <= 1'b0;
                end else begin
                    evt <= 1'b0;
                    if (rx_valid) begin
                        if (raw[gi] == lvl) begin
                            cnt <= '0;
                        end else if (cnt == 4'(DEB_FRAMES - 1)) begin
                            cnt <= '0;
                            lvl <= raw[gi];
                            evt <= raw[gi];
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            end

            assign level[gi]     = lvl;
            assign nav_event[gi] = evt;
        end
    endgenerate

endmodule

// File: rtl/cpld_link_sched.sv
// Continuous CPLD serial link: one load period plus 16 bit periods per frame, with the
// outgoing word shared round-robin between the register path and the game engine.
module cpld_link_sched
    import cpld_link_pkg::*;
#(
    parameter int CLK_DIV_LOG2 = 11,
    parameter int DEB_FRAMES   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  gnt,
    output logic        frame_done,
    output logic [12:0] rx_data,
    output logic        rx_valid,
    output logic [4:0]  nav_event,
    output logic        cpld_clk,
    output logic        cpld_ld,
    output logic        cpld_mosi,
    input  logic        cpld_miso
);

    link_state_t             state;
    logic [CLK_DIV_LOG2-1:0] div;
    logic                    sclk;
    logic [3:0]              bit_idx;
    logic [FRAME_BITS-1:0]   tx;
    logic [FRAME_BITS-1:0]   hold;
    logic [FRAME_BITS-1:0]   rx_shift;
    logic                    ptr;
    logic                    tick;
    logic                    rise_tick;
    logic                    fall_tick;
    logic [1:0]              pick;
    logic [NAV_W-1:0]        nav_level_unused;

    assign tick      = &div;
    assign rise_tick = tick & ~sclk;
    assign fall_tick = tick & sclk;
    assign pick      = arb_pick(req, ptr);

    // Pins are registered copies of the internal sequencer, so they trail it by one clk;
    // this puts the load strobe first and the DONE pulses in the last cycle of the frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= LOAD;
            div        <= '0;
            sclk       <= 1'b0;
            bit_idx    <= '0;
            tx         <= '0;
            hold       <= '0;
            rx_shift   <= '0;
            ptr        <= 1'b0;
            gnt        <= '0;
            frame_done <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            cpld_clk   <= 1'b0;
            cpld_ld    <= 1'b0;
            cpld_mosi  <= 1'b0;
        end else begin
            div        <= div + 1'b1;
            gnt        <= '0;
            frame_done <= 1'b0;
            rx_valid   <= 1'b0;
            cpld_clk   <= sclk;
            cpld_ld    <= (state != SHIFT);
            cpld_mosi  <= (state == SHIFT) ? tx[bit_idx] : 1'b0;
            if (tick) sclk <= ~sclk;

            case (state)
                LOAD: begin
                    if (fall_tick) begin
                        state   <= SHIFT;
                        bit_idx <= '0;
                    end
                end
                SHIFT: begin
                    if (rise_tick) rx_shift <= {cpld_miso, rx_shift[FRAME_BITS-1:1]};
                    if (fall_tick) begin
                        if (bit_idx == 4'd15) begin
                            state      <= DONE;
                            rx_data    <= rx_shift[RX_BITS-1:0];
                            rx_valid   <= 1'b1;
                            frame_done <= 1'b1;
                            gnt        <= pick;
                            if (pick[0]) begin
                                tx   <= data0;
                                hold <= data0;
                                ptr  <= 1'b1;
                            end else if (pick[1]) begin
                                tx   <= data1;
                                hold <= data1;
                                ptr  <= 1'b0;
                            end else begin
                                tx <= hold;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                DONE:    state <= LOAD;
                default: state <= LOAD;
            endcase
        end
    end

    // The debounced level itself is not published; only its rising events are.
    cpld_nav_debounce #(
        .DEB_FRAMES (DEB_FRAMES)
    ) u_nav_debounce (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .raw       (rx_data[NAV_LSB +: NAV_W]),
        .level     (nav_level_unused),
        .nav_event (nav_event)
    );

endmodule

// File: tb/tb_cpld_link_sched.sv
// Frame-level directed bench for cpld_link_sched with a bit-serial CPLD model.
module tb_cpld_link_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = '0;
    logic [15:0] data0 = '0;
    logic [15:0] data1 = '0;
    logic [1:0]  gnt;
    logic        frame_done;
    logic [12:0] rx_data;
    logic        rx_valid;
    logic [4:0]  nav_event;
    logic        cpld_clk;
    logic        cpld_ld;
    logic        cpld_mosi;
    logic        cpld_miso = 1'b0;

    always #5 clk = ~clk;

    cpld_link_sched #(
        .CLK_DIV_LOG2 (2),
        .DEB_FRAMES   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .gnt        (gnt),
        .frame_done (frame_done),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .nav_event  (nav_event),
        .cpld_clk   (cpld_clk),
        .cpld_ld    (cpld_ld),
        .cpld_mosi  (cpld_mosi),
        .cpld_miso  (cpld_miso)
    );

    logic [24:0] outs;
    assign outs = {gnt, frame_done, rx_data, rx_valid, nav_event, cpld_clk, cpld_ld, cpld_mosi};

    typedef struct {
        logic [1:0]  req;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] miso;
        logic [15:0] exp_mosi;
        logic [1:0]  exp_gnt;
        logic [12:0] exp_rx;
        logic [4:0]  exp_ev;
    } vec_t;

    vec_t vecs [0:27];
    int   checks = 0;
    int   errors = 0;
    logic prev_clk = 1'b0;
    int   stray;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observes frame cycles 0..135; the CPLD model shifts miso out on falling cpld_clk.
    task automatic run_frame(input logic [15:0] miso_w, output logic [15:0] mosi_w,
                             output logic [1:0] gnt_w, output logic [12:0] rx_w,
                             output logic [4:0] ev_w, output int bad);
        int nb_tx, nb_rx, rises, n_rv, n_fd;
        mosi_w = '0; gnt_w = '0; rx_w = '0; ev_w = '0; bad = 0;
        nb_tx = 0; nb_rx = 0; rises = 0; n_rv = 0; n_fd = 0;
        for (int c = 0; c < 136; c++) begin
            step();
            if (cpld_ld !== (c < 8)) bad++;
            if (!prev_clk && cpld_clk) begin
                rises++;
                if (!cpld_ld && nb_tx < 16) begin
                    mosi_w[nb_tx] = cpld_mosi;
                    nb_tx++;
                end
            end
            if (prev_clk && !cpld_clk && !cpld_ld && nb_rx < 16) begin
                cpld_miso = miso_w[nb_rx];
                nb_rx++;
            end
            prev_clk = cpld_clk;
            if (rx_valid) begin
                n_rv++;
                rx_w = rx_data;
                if (c != 135) bad++;
            end
            if (frame_done) begin
                n_fd++;
                if (c != 135) bad++;
            end
            if (gnt != 2'b00) begin
                if (c == 135) gnt_w = gnt;
                else bad++;
            end
            if (c == 0) ev_w = nav_event;
            else if (nav_event != 5'd0) bad++;
        end
        if (rises != 17 || nb_tx != 16 || nb_rx != 16 || n_rv != 1 || n_fd != 1) bad++;
    endtask

    task automatic do_frame(input string tag, input logic [1:0] r, input logic [15:0] d0,
                            input logic [15:0] d1, input logic [15:0] miso,
                            input logic [15:0] exp_mosi, input logic [1:0] exp_gnt,
                            input logic [12:0] exp_rx, input logic [4:0] exp_ev);
        logic [15:0] mosi_w;
        logic [1:0]  gnt_w;
        logic [12:0] rx_w;
        logic [4:0]  ev_w;
        int          bad;
        req = r; data0 = d0; data1 = d1;
        run_frame(miso, mosi_w, gnt_w, rx_w, ev_w, bad);
        $display("%s req=%b mosi=%h gnt=%b rx=%h nav_ev=%b timing_bad=%0d",
                 tag, r, mosi_w, gnt_w, rx_w, ev_w, bad);
        check($sformatf("%s mosi", tag), 32'(mosi_w), 32'(exp_mosi));
        check($sformatf("%s gnt", tag), 32'(gnt_w), 32'(exp_gnt));
        check($sformatf("%s rx_data", tag), 32'(rx_w), 32'(exp_rx));
        check($sformatf("%s nav_event", tag), 32'(ev_w), 32'(exp_ev));
        check($sformatf("%s timing", tag), 32'(bad), 32'd0);
    endtask

    initial begin
        //            req    d0        d1        miso      mosi      gnt    rx        ev
        vecs[0]  = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 13'h0000, 5'h00};
        vecs[1]  = '{2'b00, 16'h0000, 16'h0000, 16'h00A5, 16'h0000, 2'b00, 13'h00A5, 5'h00};
        vecs[2]  = '{2'b11, 16'h0001, 16'h8000, 16'h005A, 16'h0000, 2'b01, 13'h005A, 5'h00};
        vecs[3]  = '{2'b11, 16'h0001, 16'h8000, 16'hE0FF, 16'h0001, 2'b10, 13'h00FF, 5'h00};
        vecs[4]  = '{2'b11, 16'h0001, 16'h8000, 16'h0000, 16'h8000, 2'b01, 13'h0000, 5'h00};
        vecs[5]  = '{2'b11, 16'h0001, 16'h8000, 16'h0000, 16'h0001, 2'b10, 13'h0000, 5'h00};
        vecs[6]  = '{2'b01, 16'hA55A, 16'h8000, 16'h0000, 16'h8000, 2'b01, 13'h0000, 5'h00};
        vecs[7]  = '{2'b00, 16'hA55A, 16'h8000, 16'h0000, 16'hA55A, 2'b00, 13'h0000, 5'h00};
        vecs[8]  = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 16'hA55A, 2'b00, 13'h0000, 5'h00};
        vecs[9]  = '{2'b10, 16'h0000, 16'h1234, 16'h0000, 16'hA55A, 2'b10, 13'h0000, 5'h00};
        vecs[10] = '{2'b11, 16'h0F0F, 16'hF0F0, 16'h0000, 16'h1234, 2'b01, 13'h0000, 5'h00};
        vecs[11] = '{2'b00, 16'h0000, 16'h0000, 16'h1F3C, 16'h0F0F, 2'b00, 13'h1F3C, 5'h00};
        vecs[12] = '{2'b00, 16'h0000, 16'h0000, 16'h1F3C, 16'h0F0F, 2'b00, 13'h1F3C, 5'h00};
        vecs[13] = '{2'b00, 16'h0000, 16'h0000, 16'h1F3C, 16'h0F0F, 2'b00, 13'h1F3C, 5'h00};
        vecs[14] = '{2'b00, 16'h0000, 16'h0000, 16'h1F3C, 16'h0F0F, 2'b00, 13'h1F3C, 5'h00};
        vecs[15] = '{2'b00, 16'h0000, 16'h0000, 16'h1F3C, 16'h0F0F, 2'b00, 13'h1F3C, 5'h1F};
        vecs[16] = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 2'b00, 13'h0000, 5'h00};
        vecs[17] = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 2'b00, 13'h0000, 5'h00};
        vecs[18] = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 2'b00, 13'h0000, 5'h00};
        vecs[19] = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 2'b00, 13'h0000, 5'h00};
        vecs[20] = '{2'b00, 16'h0000, 16'h0000, 16'h0100, 16'h0F0F, 2'b00, 13'h0100, 5'h00};
        vecs[21] = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 2'b00, 13'h0000, 5'h00};
        vecs[22] = '{2'b00, 16'h0000, 16'h0000, 16'h0100, 16'h0F0F, 2'b00, 13'h0100, 5'h00};
        vecs[23] = '{2'b00, 16'h0000, 16'h0000, 16'h0100, 16'h0F0F, 2'b00, 13'h0100, 5'h00};
        vecs[24] = '{2'b00, 16'h0000, 16'h0000, 16'h0100, 16'h0F0F, 2'b00, 13'h0100, 5'h00};
        vecs[25] = '{2'b00, 16'h0000, 16'h0000, 16'h0100, 16'h0F0F, 2'b00, 13'h0100, 5'h00};
        vecs[26] = '{2'b00, 16'h0000, 16'h0000, 16'h0100, 16'h0F0F, 2'b00, 13'h0100, 5'h01};
        vecs[27] = '{2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0F0F, 2'b00, 13'h0000, 5'h00};

        rst = 1'b0;
        repeat (3) step();
        check("reset_outputs", 32'(outs), 32'd0);
        rst = 1'b1;
        prev_clk = 1'b0;

        for (int i = 0; i < 28; i++) begin
            do_frame($sformatf("frame%0d", i), vecs[i].req, vecs[i].d0, vecs[i].d1,
                     vecs[i].miso, vecs[i].exp_mosi, vecs[i].exp_gnt,
                     vecs[i].exp_rx, vecs[i].exp_ev);
        end

        // Grant 16'hBEEF, then reset partway through the frame that carries it.
        do_frame("grant_beef", 2'b01, 16'hBEEF, 16'h0000, 16'h0000,
                 16'h0F0F, 2'b01, 13'h0000, 5'h00);
        req = 2'b00;
        stray = 0;
        for (int c = 0; c <= 70; c++) begin
            step();
            if (c == 12) check("abort_frame_tx_bit0", 32'(cpld_mosi), 32'd1);
            if (rx_valid || frame_done || gnt != 2'b00) stray++;
        end
        check("abort_frame_no_pulse", 32'(stray), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("mid_reset_outputs%0d", k), 32'(outs), 32'd0);
        end
        rst = 1'b1;
        prev_clk = 1'b0;
        cpld_miso = 1'b0;

        do_frame("post_reset0", 2'b00, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 2'b00, 13'h0000, 5'h00);
        do_frame("post_reset1", 2'b10, 16'h0000, 16'hC3C3, 16'h0000,
                 16'h0000, 2'b10, 13'h0000, 5'h00);
        do_frame("post_reset2", 2'b00, 16'h0000, 16'h0000, 16'h0000,
                 16'hC3C3, 2'b00, 13'h0000, 5'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpld_link_sched.md
Name: cpld_link_sched

Overview:
Owns the serial link to the board CPLD (LEDs, 7-segment, DIP switches, nav switches) and shares its 16-bit output frame between two requesters. Requester 0 is the AXI register path and requester 1 is the hardware game engine.
Runs frames back-to-back so the inputs are polled continuously. Publishes the received switch word and debounced nav-switch press events.

Parameters:
CLK_DIV_LOG2, 11, half serial period = 2^CLK_DIV_LOG2 clk cycles
DEB_FRAMES, 4, consecutive identical frames needed to accept a nav level change (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
req  in  2  per-requester frame request; level, held until granted
data0  in  16  requester 0 frame {seg[15:8], led[7:0]}
data1  in  16  requester 1 frame, same format
gnt  out  2  one-cycle pulse: that requester's data was captured for the next frame
frame_done  out  1  one-cycle pulse at end of every frame
rx_data  out  13  last received {nav[12:8], sw[7:0]}
rx_valid  out  1  one-cycle pulse when rx_data updates
nav_event  out  5  one-cycle pulse per nav bit on a debounced 0->1 transition
cpld_clk  out  1  serial clock
cpld_ld  out  1  parallel load/latch strobe
cpld_mosi  out  1  serial data to CPLD
cpld_miso  in  1  serial data from CPLD

Behaviour:
- Reset when rst==0: all outputs 0; hold word 0; round-robin pointer -> requester 0; divider 0; state LOAD.
- Reset asserted mid-frame aborts the frame immediately with no gnt, rx_valid or frame_done. The first frame after release starts at divider 0.
- Divider: a CLK_DIV_LOG2-bit counter produces a tick on wrap. cpld_clk toggles on each tick, so the bit period is 2^(CLK_DIV_LOG2+1) clk.
- Rise tick: cpld_clk 0->1. Fall tick: cpld_clk 1->0.
- Frame = 1 load period + 16 bit periods = 17*2^(CLK_DIV_LOG2+1) clk. Frames repeat with no gap.
- States:
  - LOAD: cpld_ld=1 for one full bit period. On the fall tick ending it, go to SHIFT with bit index 0.
  - SHIFT: cpld_mosi = tx[bit], LSB first, updated only on fall ticks. cpld_miso is sampled on rise ticks into rx_shift, LSB first. After the 16th fall tick, go to DONE.
  - DONE (1 clk):
    - rx_data <= rx_shift[12:0]; rx_valid=1; frame_done=1.
    - Arbitrate and load tx.
    - Go to LOAD. The divider keeps running, so the load period starts on schedule.
- Arbitration (DONE cycle only):
  - Both req set: grant the requester at the pointer, then flip the pointer.
  - Only one set: grant it, and the pointer moves to the other requester.
  - None set: tx <= hold word, no gnt.
  - A granted word also becomes the hold word.
- gnt pulses in the DONE cycle; the data is sampled in that same cycle.
- A req deasserted before grant has no effect. A req re-asserted in the gnt cycle is seen at the next DONE.
- Arbitration latency from req to gnt is at most 2 frames.
- tx/rx widths are fixed at 16. rx_shift[15:13] are discarded.
- Nav debounce, per bit:
  - A counter increments on rx_valid while the raw bit differs from the debounced level, and clears when it matches.
  - At DEB_FRAMES the debounced level takes the raw value and the counter clears.
  - nav_event[i] pulses in the cycle after rx_valid when debounced bit i goes 0->1.
  - 1->0 changes produce no event.
- The sw bits rx_data[7:0] are not debounced.

Decomposition:
- Package cpld_link_pkg:
  - FRAME_BITS=16, RX_BITS=13, SW_LSB=0, NAV_LSB=8, NAV_W=5
  - state encoding LOAD/SHIFT/DONE
- Sub-module cpld_nav_debounce (NAV_W lanes, DEB_FRAMES parameter): inputs rx_valid and raw nav; outputs debounced level and nav_event.

Test Plan:
All scenarios use CLK_DIV_LOG2=2, so the bit period is 8 clk and a frame is 136 clk.
- Reset, no req, miso=0:
  - first frame: ld=1 for clk 0..7, mosi=0 for 16 bits, rx_valid at clk 135 with rx_data=0;
  - frames continue every 136 clk.
- req=01, data0=16'hA55A:
  - gnt=01 at the first DONE;
  - next frame's mosi, sampled on rise edges, reads bits 0,1,0,1,1,0,1,0,... (LSB first);
  - with req dropped, the following frame repeats 16'hA55A from the hold word.
- req=11 held, data0=16'h0001, data1=16'h8000:
  - gnt alternates 01,10,01,10 over 4 frames;
  - the transmitted words alternate to match.
- CPLD model returning 16'h1F3C:
  - rx_data=13'h1F3C after one frame;
  - nav_event=5'b11111 exactly once, at the 4th consecutive frame (DEB_FRAMES=4).
- Nav bit 0 bounce 1,0,1,1,1,1 over 6 frames: nav_event[0] pulses once, after frame 6.
- rst asserted at clk 70 of a granted frame for 3 clk:
  - no rx_valid, gnt or frame_done occurs;
  - the outputs read 0 in the cycle after each reset-asserted edge;
  - hold word=0 and the next frame transmits 0 unless a req is pending.
